// File: rtl/factorial_controller.sv
// rtl/factorial_controller.sv - Moore FSM sequencing a register-file/ALU datapath to compute n! mod 256
// R0 holds the down-counter, R1 the running product; compare only steers next state.
module factorial_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       compare,
  output logic       IE,
  output logic       we,
  output logic [1:0] wa,
  output logic       rea,
  output logic       reb,
  output logic [1:0] raa,
  output logic [1:0] rab,
  output logic [2:0] Sel_alu,
  output logic       OE,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_DEC = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD0 = 4'd1,
    S_LOAD1 = 4'd2,
    S_CHECK = 4'd3,
    S_DEC   = 4'd4,
    S_MUL   = 4'd5,
    S_FINAL = 4'd6,
    S_ZERO  = 4'd7,
    S_ONE   = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_IDLE;
    IE         = 1'b0;
    we         = 1'b0;
    wa         = 2'd0;
    rea        = 1'b0;
    reb        = 1'b0;
    raa        = 2'd0;
    rab        = 2'd0;
    Sel_alu    = 3'b000;
    OE         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        next_state = start ? S_LOAD0 : S_IDLE;
      end
      S_LOAD0: begin
        busy       = 1'b1;
        IE         = 1'b1;
        we         = 1'b1;
        wa         = 2'd0;
        next_state = S_LOAD1;
      end
      S_LOAD1: begin
        busy       = 1'b1;
        IE         = 1'b1;
        we         = 1'b1;
        wa         = 2'd1;
        next_state = S_CHECK;
      end
      // R0|R0 passes n through the ALU so compare can flag n <= 1
      S_CHECK: begin
        busy       = 1'b1;
        rea        = 1'b1;
        reb        = 1'b1;
        Sel_alu    = ALU_OR;
        next_state = compare ? S_ZERO : S_DEC;
      end
      S_DEC: begin
        busy       = 1'b1;
        rea        = 1'b1;
        Sel_alu    = ALU_DEC;
        we         = 1'b1;
        wa         = 2'd0;
        next_state = compare ? S_FINAL : S_MUL;
      end
      S_MUL: begin
        busy       = 1'b1;
        rea        = 1'b1;
        reb        = 1'b1;
        raa        = 2'd1;
        Sel_alu    = ALU_MUL;
        we         = 1'b1;
        wa         = 2'd1;
        next_state = S_DEC;
      end
      S_FINAL: begin
        busy       = 1'b1;
        rea        = 1'b1;
        reb        = 1'b1;
        raa        = 2'd1;
        rab        = 2'd1;
        Sel_alu    = ALU_OR;
        OE         = 1'b1;
        next_state = S_DONE;
      end
      // R0^R0 clears R1 so the following increment yields 1
      S_ZERO: begin
        busy       = 1'b1;
        rea        = 1'b1;
        reb        = 1'b1;
        Sel_alu    = ALU_XOR;
        we         = 1'b1;
        wa         = 2'd1;
        next_state = S_ONE;
      end
      S_ONE: begin
        busy       = 1'b1;
        rea        = 1'b1;
        raa        = 2'd1;
        Sel_alu    = ALU_INC;
        OE         = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_factorial_controller.sv
// tb/tb_factorial_controller.sv - bench for factorial_controller with a behavioural register-file/ALU datapath
module tb_factorial_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       compare;
  logic       IE, we, rea, reb, OE, busy, done;
  logic [1:0] wa, raa, rab;
  logic [2:0] Sel_alu;
  logic [7:0] data_i = 8'd0;

  factorial_controller dut (
    .clk(clk), .rst(rst), .start(start), .compare(compare),
    .IE(IE), .we(we), .wa(wa), .rea(rea), .reb(reb),
    .raa(raa), .rab(rab), .Sel_alu(Sel_alu), .OE(OE),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath the controller drives; deliberately not cleared by rst
  logic [7:0]  rf [4];
  logic [7:0]  a_val, b_val, alu, out_q;
  logic [15:0] prod;

  always_comb begin
    a_val = rea ? rf[raa] : 8'd0;
    b_val = reb ? rf[rab] : 8'd0;
    prod  = a_val * b_val;
    case (Sel_alu)
      3'b010:  alu = prod[7:0];
      3'b100:  alu = a_val | b_val;
      3'b101:  alu = a_val ^ b_val;
      3'b110:  alu = a_val + 8'd1;
      3'b111:  alu = a_val - 8'd1;
      default: alu = 8'd0;
    endcase
    compare = (alu <= 8'd1);
  end

  always @(posedge clk) begin
    if (we) rf[wa] <= IE ? data_i : alu;
    if (OE) out_q <= alu;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] val;
    int         cyc;
    int         n;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] fact_mod(input int n);
    int r = 1;
    for (int i = 2; i <= n; i++) r = (r * i) % 256;
    return r[7:0];
  endfunction

  function automatic int latency(input int n);
    return (n <= 1) ? 6 : 2 * n + 2;
  endfunction

  function automatic logic [15:0] out_vec();
    return {IE, we, wa, rea, reb, raa, rab, Sel_alu, OE, busy, done};
  endfunction

  // Called at a negedge with the FSM in IDLE: the next edge samples start,
  // and done is visible at the negedge following edge k + latency - 1.
  task automatic launch(input int n);
    exp_t e;
    data_i = n[7:0];
    start  = 1'b1;
    e.val  = fact_mod(n);
    e.cyc  = cyc + latency(n);
    e.n    = n;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit toggle, output bit seen, output logic [7:0] o,
                           output int c, output int bsy, output int muls, output int zeros);
    bit released = 1'b0;
    seen = 1'b0; o = 8'd0; c = 0; bsy = 0; muls = 0; zeros = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        o    = out_q;
        c    = cyc;
        break;
      end
      if (busy) begin
        bsy++;
        if (!released) begin
          start    = 1'b0;
          released = 1'b1;
        end else if (toggle) begin
          start = 1'($urandom_range(0, 1));
        end
      end
      if (Sel_alu == 3'b010) muls++;
      if (Sel_alu == 3'b101) zeros++;
    end
  endtask

  task automatic test_reset();
    bit seen; logic [7:0] o; int c, bsy, muls, zeros;
    exp_t e;
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0000", out_vec());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    launch(2);
    wait_done(1'b0, seen, o, c, bsy, muls, zeros);
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL first_start_timeout n=2 no done within budget");
    end else if (c !== e.cyc || o !== e.val) begin
      failures++;
      $display("FAIL first_start got out=%0d cyc=%0d want out=%0d cyc=%0d", o, c, e.val, e.cyc);
    end
  endtask

  task automatic test_factorials();
    int ns[10] = '{5, 2, 3, 6, 0, 1, 4, 7, 8, 255};
    bit seen; logic [7:0] o; int c, bsy, muls, zeros;
    exp_t e;
    foreach (ns[i]) begin
      @(negedge clk);
      launch(ns[i]);
      wait_done(1'b0, seen, o, c, bsy, muls, zeros);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL fact_timeout n=%0d no done within budget", e.n);
        continue;
      end
      if (o !== e.val) begin
        failures++;
        $display("FAIL fact_out n=%0d got=%0d want=%0d", e.n, o, e.val);
      end
      checks++;
      if (c !== e.cyc) begin
        failures++;
        $display("FAIL fact_latency n=%0d got_cyc=%0d want_cyc=%0d", e.n, c, e.cyc);
      end
      checks++;
      if (bsy !== latency(e.n) - 1) begin
        failures++;
        $display("FAIL busy_cycles n=%0d got=%0d want=%0d", e.n, bsy, latency(e.n) - 1);
      end
      checks++;
      if (muls !== ((e.n > 2) ? e.n - 2 : 0) || zeros !== ((e.n <= 1) ? 1 : 0)) begin
        failures++;
        $display("FAIL state_path n=%0d got mul=%0d zero=%0d", e.n, muls, zeros);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse n=%0d got done=%b busy=%b want 0 0", e.n, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen, hit, extra; logic [7:0] o; int c, bsy, muls, zeros;
    exp_t e;
    @(negedge clk);
    launch(5);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) start = 1'b0;
      if (Sel_alu == 3'b010) begin
        hit = 1'b1;
        break;
      end
    end
    void'(sb.pop_back());
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_run_mul_timeout MUL state never reached");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0000", out_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL aborted_run got done/busy after reset want none");
    end
    launch(4);
    wait_done(1'b0, seen, o, c, bsy, muls, zeros);
    e = sb.pop_front();
    checks++;
    if (!seen || o !== e.val || c !== e.cyc) begin
      failures++;
      $display("FAIL rerun_after_reset seen=%b got out=%0d cyc=%0d want out=%0d cyc=%0d", seen, o, c, e.val, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; logic [7:0] o; int c, bsy, muls, zeros;
    exp_t e, e2;
    @(negedge clk);
    launch(3);
    wait_done(1'b1, seen, o, c, bsy, muls, zeros);
    e = sb.pop_front();
    checks++;
    if (!seen || o !== e.val || c !== e.cyc) begin
      failures++;
      $display("FAIL toggle_busy seen=%b got out=%0d cyc=%0d want out=%0d cyc=%0d", seen, o, c, e.val, e.cyc);
    end
    // start held through DONE: IDLE follows, and the edge after that samples it
    data_i = 8'd4;
    start  = 1'b1;
    e2.val = fact_mod(4);
    e2.cyc = c + 1 + latency(4);
    e2.n   = 4;
    sb.push_back(e2);
    wait_done(1'b0, seen, o, c, bsy, muls, zeros);
    e = sb.pop_front();
    checks++;
    if (!seen || o !== e.val || c !== e.cyc) begin
      failures++;
      $display("FAIL held_start seen=%b got out=%0d cyc=%0d want out=%0d cyc=%0d", seen, o, c, e.val, e.cyc);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_factorials();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
